// File: rtl/sample_ram_responder.sv
// Block-RAM responder for the sample store's memory request interface.
// Clears memory after reset, serves reads with a fixed latency and buffers one write during reads.
module sample_ram_responder #(
  parameter int unsigned DEPTH_LOG2     = 14,
  parameter int unsigned READ_LATENCY   = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] address,
  input  logic [15:0] data_in,
  input  logic        write_enable,
  input  logic        read_request,
  input  logic        read_ack,
  output logic [15:0] data_out,
  output logic        rd_data_pres,
  output logic        rdy,
  output logic [25:0] max_ram_address,
  output logic        overrun,
  output logic        oor_err
);

  localparam int unsigned AW    = 26;
  localparam int unsigned DW    = 16;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR     = 2'd0,
    S_IDLE      = 2'd1,
    S_READ_WAIT = 2'd2,
    S_READ_HOLD = 2'd3
  } state_t;

  logic [DW-1:0] r_mem [DEPTH];

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic            r_we_q;
  logic            r_pend;
  logic [AW-1:0]   r_pend_addr;
  logic [DW-1:0]   r_pend_data;
  logic [AW-1:0]   r_rd_addr;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_data_out;
  logic            r_pres;
  logic            r_rdy;
  logic            r_overrun;
  logic            r_oor;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_ptr_nxt;
  logic            w_we_rise;
  logic            w_pend_nxt;
  logic [AW-1:0]   w_pend_addr_nxt;
  logic [DW-1:0]   w_pend_data_nxt;
  logic [AW-1:0]   w_rd_addr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_pres_nxt;
  logic            w_rdy_nxt;
  logic            w_overrun_nxt;
  logic            w_oor_nxt;
  logic            w_load;
  logic            w_load_zero;
  logic            w_commit;
  logic [AW-1:0]   w_c_addr;
  logic [DW-1:0]   w_c_data;
  logic            w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_addr;
  logic [DW-1:0]   w_mem_wdata;

  // Next-state, memory port mux and output next values
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_we_rise       = write_enable & ~r_we_q;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_data_nxt = r_pend_data;
    w_rd_addr_nxt   = r_rd_addr;
    w_cnt_nxt       = r_cnt;
    w_pres_nxt      = r_pres;
    w_rdy_nxt       = r_rdy;
    w_overrun_nxt   = r_overrun;
    w_oor_nxt       = r_oor;
    w_load          = 1'b0;
    w_load_zero     = 1'b0;
    w_commit        = 1'b0;
    w_c_addr        = address;
    w_c_data        = data_in;
    w_mem_we        = 1'b0;
    w_mem_addr      = r_rd_addr[DEPTH_LOG2-1:0];
    w_mem_wdata     = '0;

    case (r_state)
      S_CLEAR: begin
        if (!CLEAR_ON_RESET || r_ptr[DEPTH_LOG2]) begin
          w_state_nxt = S_IDLE;
          w_rdy_nxt   = 1'b1;
        end else begin
          w_mem_we   = 1'b1;
          w_mem_addr = r_ptr[DEPTH_LOG2-1:0];
          w_ptr_nxt  = r_ptr + PW'(1);
        end
      end
      S_IDLE: begin
        if (r_pend) begin
          // A new edge arriving while the buffered write drains refills the buffer
          w_commit        = 1'b1;
          w_c_addr        = r_pend_addr;
          w_c_data        = r_pend_data;
          w_pend_nxt      = w_we_rise;
          w_pend_addr_nxt = address;
          w_pend_data_nxt = data_in;
        end else if (w_we_rise) begin
          w_commit = 1'b1;
        end else if (read_request) begin
          w_rd_addr_nxt = address;
          w_cnt_nxt     = CW'(READ_LATENCY);
          w_state_nxt   = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (r_cnt == '0) begin
          w_load      = 1'b1;
          w_pres_nxt  = 1'b1;
          w_state_nxt = S_READ_HOLD;
          if (r_rd_addr > MAX_ADDR) begin
            w_load_zero = 1'b1;
            w_oor_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_READ_HOLD: begin
        if (read_ack) begin
          w_pres_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase

    if ((r_state == S_READ_WAIT || r_state == S_READ_HOLD) && w_we_rise) begin
      w_pend_nxt      = 1'b1;
      w_pend_addr_nxt = address;
      w_pend_data_nxt = data_in;
      if (r_pend) w_overrun_nxt = 1'b1;
    end

    if (w_commit) begin
      if (w_c_addr <= MAX_ADDR) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = w_c_addr[DEPTH_LOG2-1:0];
        w_mem_wdata = w_c_data;
      end else begin
        w_oor_nxt = 1'b1;
      end
    end

    if (reset) w_mem_we = 1'b0;
  end

  // Single-port storage
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_ptr       <= '0;
      r_we_q      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_rd_addr   <= '0;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_pres      <= 1'b0;
      r_rdy       <= 1'b0;
      r_overrun   <= 1'b0;
      r_oor       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_we_q      <= write_enable;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pres      <= w_pres_nxt;
      r_rdy       <= w_rdy_nxt;
      r_overrun   <= w_overrun_nxt;
      r_oor       <= w_oor_nxt;
      if (w_load) r_data_out <= w_load_zero ? '0 : r_mem[w_mem_addr];
    end
  end

  assign data_out        = r_data_out;
  assign rd_data_pres    = r_pres;
  assign rdy             = r_rdy;
  assign overrun         = r_overrun;
  assign oor_err         = r_oor;
  assign max_ram_address = MAX_ADDR;

endmodule

// File: doc/sample_ram_responder.md
# sample_ram_responder

On-chip block-RAM responder for the audio sample store's memory request interface: write pulse, read request/acknowledge, data-present flag, ready, and maximum address. It serves the recorder's memory FSMD on boards or bench builds without the DDR core, and drops in where the DDR wrapper sits. It owns power-on clearing, the read-latency pipeline, and the rules for out-of-range access and request collisions.

## Interface
- DEPTH_LOG2, 14: storage depth is 2^DEPTH_LOG2 words of 16 bits.
- READ_LATENCY, 2: idle cycles between accepting a read and presenting data; range 1–8.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = skip clearing.
- clk  in  1  single clock; every register uses the rising edge.
- reset  in  1  synchronous, active-high.
- address  in  26  word address for the write or read.
- data_in  in  16  write data.
- write_enable  in  1  write strobe; its rising edge commits one write.
- read_request  in  1  read strobe, level-sampled.
- read_ack  in  1  consumer has taken data_out.
- data_out  out  16  read data, valid while rd_data_pres=1.
- rd_data_pres  out  1  read data available.
- rdy  out  1  responder is initialised and accepting requests.
- max_ram_address  out  26  constant 2^DEPTH_LOG2−1, zero-extended.
- overrun  out  1  sticky: a pending write was overwritten.
- oor_err  out  1  sticky: an access had address > max_ram_address.

## Operation
- Reset values: data_out=0, rd_data_pres=0, rdy=0, overrun=0, oor_err=0, state CLEAR, clear pointer 0, pending flag 0, write-edge register 0.
- States: CLEAR, IDLE, READ_WAIT, READ_HOLD.
- CLEAR:
  - Writes 0 to word[ptr] and increments ptr, one word per cycle.
  - After word 2^DEPTH_LOG2−1 is written, goes to IDLE and sets rdy=1.
  - With CLEAR_ON_RESET=0, goes to IDLE on the first edge with reset low.
  - Write edges and read requests during CLEAR are ignored (not pended).
- Write edge: weR = write_enable & ~write_enable_q, evaluated every cycle outside CLEAR.
  - A level held for many cycles produces exactly one write.
- IDLE, priority order:
  - (1) pending write: commit it, clear pending.
  - (2) otherwise weR: commit {address, data_in}.
  - (3) otherwise read_request: latch address, load latency counter with READ_LATENCY, go to READ_WAIT.
  - A write has priority in the same cycle. read_request is not remembered and must still be high on a later IDLE cycle to be accepted.
- Write commit:
  - If address ≤ max_ram_address: store data_in at address[DEPTH_LOG2−1:0].
  - Otherwise: drop the write and set oor_err.
- weR in READ_WAIT or READ_HOLD:
  - Captures {address, data_in} into a one-deep pending register and sets pending.
  - If pending is already 1, the new capture replaces it and overrun is set.
- READ_WAIT:
  - Counter decrements each cycle. At 0, data_out is loaded and rd_data_pres=1, state goes to READ_HOLD.
  - Loaded value is mem[latched address], or 0 with oor_err set if the latched address > max_ram_address.
- READ_HOLD:
  - data_out and rd_data_pres are held until read_ack=1 is sampled.
  - On that edge rd_data_pres=0 and state goes to IDLE. data_out keeps its last value.
  - read_request while in READ_WAIT or READ_HOLD is ignored.
- rdy is 0 only in CLEAR or during reset.
- overrun and oor_err clear only on reset.
- Reset mid-operation: any state goes to CLEAR on the next edge. In-flight read and pending write are discarded, and every output returns to its reset value.

## Timing
- Write: weR sampled in IDLE at edge N → word updated at edge N. A read accepted at edge N+1 returns the new value.
- Read: request accepted at edge N → rd_data_pres=1 and data_out valid after edge N+READ_LATENCY+1.
- Ack sampled at edge K → rd_data_pres=0 after edge K. Earliest next read acceptance is edge K+1, or K+2 if a pending write commits at K+1.
- Clear:
  - With CLEAR_ON_RESET=1, rdy=1 exactly 2^DEPTH_LOG2+1 edges after the first edge with reset low.
  - With CLEAR_ON_RESET=0, rdy=1 after 1 edge.
- Memory is a single-port array; the clear, commit and read-address paths are muxed by state. No combinational path runs from inputs to outputs.

## Test plan
- DEPTH_LOG2=4, CLEAR_ON_RESET=1: release reset, then read every address → rdy rises exactly 17 cycles after release, all reads return 0x0000, max_ram_address=15.
- Write 0xA5A5 @3 with a 1-cycle strobe, then write 0x1234 @3 with the strobe held 5 cycles, then read @3 → data 0x1234, exactly one write committed per strobe, overrun=0, oor_err=0.
- READ_LATENCY=2: request @3 at edge N with read_ack held low 10 cycles → rd_data_pres high after N+3 and held with a stable data_out until ack; clears the edge after ack.
- Write edge and read_request in the same IDLE cycle (write 0x00FF @5, read @5 held) → write commits first, read is accepted the next cycle and returns 0x00FF.
- Two write edges (@1 = 0x1111, @2 = 0x2222) during READ_HOLD → overrun=1; after ack only @2 = 0x2222 is written, @1 keeps its old value.
- Read @16 with DEPTH_LOG2=4 → data_out=0, oor_err=1; reset asserted mid-READ_WAIT → rd_data_pres stays 0, oor_err clears, CLEAR restarts.
